ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch stage directly upstream of the 8 KiB x 8 program ROM in the MCS8 core.
- Drives the ROM's chip-select, read strobe and 13-bit address, and captures the returned byte.
- Buffers fetched bytes in a small prefetch queue, with addresses, toward the instruction decoder using a valid/ready handshake.
- Handles jumps by flushing the queue and redirecting the fetch address.

Parameters:
- ADDR_W, 13, ROM byte-address width; fetch address wraps modulo 2^ADDR_W.
- DAT_W, 8, ROM data width.
- QDEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 13'h0000, first fetch address after reset.

Ports:
- CLK_I, input, 1, system clock; all state updates on the rising edge.
- RSTN_I, input, 1, reset; asynchronous, active-low.
- ROM_CS_O, input to ROM, output here, 1, ROM chip-select; registered.
- ROM_RD_O, output, 1, ROM read strobe; registered; always equal to ROM_CS_O.
- ROM_ADDR_O, output, ADDR_W, ROM byte address; registered.
- ROM_DAT_I, input, DAT_W, ROM read data; combinational from ROM_ADDR_O; forced to 0 when the strobes are low.
- JMP_I, input, 1, one-cycle redirect request.
- JMP_ADDR_I, input, ADDR_W, redirect target; sampled when JMP_I=1.
- HOLD_I, input, 1, suppresses issue of new fetches; does not drain the queue.
- OP_VALID_O, output, 1, queue head valid.
- OP_READY_I, input, 1, decoder accepts the head; a pop occurs when OP_VALID_O & OP_READY_I.
- OP_DAT_O, output, DAT_W, head byte.
- OP_ADDR_O, output, ADDR_W, ROM address of the head byte.

Behaviour:
- Reset (RSTN_I=0, asynchronous) forces the following:
  - ROM_CS_O=ROM_RD_O=0; ROM_ADDR_O=RESET_PC.
  - OP_VALID_O=0, OP_DAT_O=0, OP_ADDR_O=0.
  - Queue count 0; FSM=IDLE.
- Reset asserted mid-fetch discards everything. No partial state survives.
- FSM states:
  - IDLE: strobes low. Goes to RUN on the next edge.
  - RUN: issue and capture active.
  - FLUSH: strobes low for exactly one cycle. Goes to RUN on the next edge.
- Capture: on any edge where ROM_CS_O=1 and the FSM is RUN with no JMP_I, write {ROM_ADDR_O, ROM_DAT_I} into the queue tail.
- Issue:
  - Compute space = QDEPTH - count + pop - capture.
  - On each edge in RUN (or on the IDLE->RUN and FLUSH->RUN transitions), set the strobes for the next cycle to 1 iff space>0 and HOLD_I=0.
  - Increment ROM_ADDR_O by 1 after every capture; 2^ADDR_W-1 wraps to 0.
  - Throughput is 1 byte/cycle when the decoder pops every cycle.
- Latency: a captured byte appears on OP_VALID_O/OP_DAT_O in the cycle after its capture edge. The queue output is registered; there is no same-cycle bypass.
- Queue ordering: strict FIFO.
  - Simultaneous pop and capture is legal when the queue is full. Count is unchanged.
  - A pop while empty is impossible by construction, because OP_VALID_O=0.
- Jump (JMP_I=1 at an edge) has priority over everything else:
  - Queue cleared; OP_VALID_O=0 next cycle.
  - Any same-edge capture is discarded, and any same-edge pop is ignored.
  - ROM_ADDR_O<=JMP_ADDR_I; strobes<=0; FSM<=FLUSH.
  - JMP_I in FLUSH or IDLE also reloads ROM_ADDR_O and stays in or enters FLUSH.
- HOLD_I=1: the current strobed cycle still captures. No new strobe is issued. The queue keeps draining normally.
- OP_DAT_O and OP_ADDR_O hold their value while OP_VALID_O=0.

Optional Feature:
- Macro: IFETCH_FLUSHCNT_EN.
- Defined:
  - Adds output FLUSH_CNT_O[15:0], reset to 0.
  - On each JMP_I edge, adds the number of discarded bytes (queue count plus 1 if a capture was discarded).
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared include ifetch_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, FLUSH=2'd2.
  - Default ADDR_W/DAT_W values shared with the ROM and decoder.
- One natural sub-module: fifo_sync.
  - Parameterised width/depth synchronous FIFO with synchronous clear.
  - Outputs count, empty, full and registered head.
  - Instantiated with width ADDR_W+DAT_W.

Test Plan:
- Cold start, ROM bytes 0..7 = 8'h10..8'h17, OP_READY_I=1:
  - Cycle 1 after reset release: ROM_CS_O=1, ROM_ADDR_O=0.
  - Next cycle: OP_VALID_O=1, OP_DAT_O=8'h10, OP_ADDR_O=0.
  - Thereafter one byte per cycle: 8'h11, 8'h12, and so on.
- Backpressure: OP_READY_I=0 from reset.
  - Exactly QDEPTH=4 captures occur at addresses 0..3, then the strobes drop.
  - Raising OP_READY_I delivers 0..3 in order, then 4 onward with no gap longer than 1 cycle.
- Jump while the queue holds 3 bytes: JMP_I=1, JMP_ADDR_I=13'h0100.
  - Next cycle: OP_VALID_O=0 and the strobes are low (FLUSH).
  - Then a fetch at 13'h0100.
  - The first delivered OP_ADDR_O is 13'h0100. With IFETCH_FLUSHCNT_EN, FLUSH_CNT_O=3 or 4.
- Wrap: jump to 13'h1FFE. Delivered OP_ADDR_O sequence: 1FFE, 1FFF, 0000, 0001.
- Async reset asserted mid-stream, between clock edges: all outputs go to reset values immediately. After release the fetch restarts at RESET_PC.
- HOLD_I=1 for 5 cycles with OP_READY_I=1: no strobes issue and the queue drains to empty. After HOLD_I deasserts, the fetch resumes at the next sequential address with no byte skipped or duplicated.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared definitions for the MCS8 instruction-fetch stage.
//   - fetch_state_t : fetch FSM encodings (IDLE=0, RUN=1, FLUSH=2)
//   - IFQ_ADDR_W / IFQ_DAT_W : default ROM address/data widths shared with
//     the program ROM and the decoder
//   - sat_add16 : 16-bit saturating add used by the optional flush counter
package ifetch_queue_pkg;

  localparam int IFQ_ADDR_W = 13;
  localparam int IFQ_DAT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo_sync.sv
// fifo_sync: parameterised synchronous FIFO with synchronous clear and a
// registered head word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear (priority over wr_en/rd_en); head holds
//   wr_en/wr_data: push (ignored when full unless a pop happens on the same edge)
//   rd_en        : pop the head (ignored when empty)
//   head         : registered head entry; a word written into an empty FIFO
//                  appears here the cycle after the write edge
//   count/empty/full : occupancy status
module fifo_sync #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             pop, push;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    head_next   = head_reg;
    // Writing into a queue that is (or becomes) empty: the new word is the head.
    if (push && ((count_reg - CNT_W'(pop)) == '0)) begin
      head_next = wr_data;
    end else if (pop && (count_next != '0)) begin
      // Next head already lives in the array.
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: MCS8 instruction-fetch stage in front of the 8 KiB x 8 ROM.
// Issues registered ROM reads, queues {address, byte} pairs in a prefetch
// FIFO and hands them to the decoder over a valid/ready handshake. A jump
// flushes the queue, reloads the fetch address and idles the strobes for
// one FLUSH cycle.
// Ports:
//   CLK_I, RSTN_I            : clock, asynchronous active-low reset
//   ROM_CS_O/ROM_RD_O        : registered ROM strobes (always equal)
//   ROM_ADDR_O, ROM_DAT_I    : ROM address (registered) and returned byte
//   JMP_I, JMP_ADDR_I        : one-cycle redirect request and target
//   HOLD_I                   : stop issuing new fetches (queue still drains)
//   OP_VALID_O/OP_READY_I    : decoder handshake; OP_DAT_O/OP_ADDR_O head
//   FLUSH_CNT_O              : discarded-byte counter, only when the macro
//                              IFETCH_FLUSHCNT_EN is defined
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = IFQ_ADDR_W,
  parameter int                DAT_W    = IFQ_DAT_W,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK_I,
  input  logic              RSTN_I,
  output logic              ROM_CS_O,
  output logic              ROM_RD_O,
  output logic [ADDR_W-1:0] ROM_ADDR_O,
  input  logic [DAT_W-1:0]  ROM_DAT_I,
  input  logic              JMP_I,
  input  logic [ADDR_W-1:0] JMP_ADDR_I,
  input  logic              HOLD_I,
  output logic              OP_VALID_O,
  input  logic              OP_READY_I,
  output logic [DAT_W-1:0]  OP_DAT_O,
  output logic [ADDR_W-1:0] OP_ADDR_O
`ifdef IFETCH_FLUSHCNT_EN
  ,
  output logic [15:0]       FLUSH_CNT_O
`endif
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t              state_reg, state_next;
  logic                      cs_reg, cs_next;
  logic [ADDR_W-1:0]         addr_reg, addr_next;
  logic                      capture, pop;
  logic [CNT_W-1:0]          q_count;
  logic                      q_empty, full_unused;
  logic [ADDR_W+DAT_W-1:0]   q_head;
  logic [OCC_W-1:0]          occ_next;
  logic                      space_avail;

  // A strobed RUN cycle returns its byte at the edge; a jump discards it.
  assign capture = cs_reg && (state_reg == RUN) && !JMP_I;
  assign pop     = OP_VALID_O && OP_READY_I && !JMP_I;

  // space > 0  <=>  occupancy after this edge is below QDEPTH.
  assign occ_next    = OCC_W'(q_count) + OCC_W'(capture) - OCC_W'(pop);
  assign space_avail = (occ_next < OCC_W'(QDEPTH));

  always_comb begin
    state_next = state_reg;
    cs_next    = 1'b0;
    addr_next  = addr_reg;
    if (JMP_I) begin
      state_next = FLUSH;
      addr_next  = JMP_ADDR_I;
    end else begin
      case (state_reg)
        IDLE, FLUSH: begin
          state_next = RUN;
          cs_next    = space_avail && !HOLD_I;
        end
        RUN: begin
          cs_next = space_avail && !HOLD_I;
          if (capture) begin
            addr_next = addr_reg + ADDR_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_reg <= IDLE;
      cs_reg    <= 1'b0;
      addr_reg  <= RESET_PC;
    end else begin
      state_reg <= state_next;
      cs_reg    <= cs_next;
      addr_reg  <= addr_next;
    end
  end

  fifo_sync #(
    .WIDTH(ADDR_W + DAT_W),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk    (CLK_I),
    .rst_n  (RSTN_I),
    .clr    (JMP_I),
    .wr_en  (capture),
    .wr_data({addr_reg, ROM_DAT_I}),
    .rd_en  (pop),
    .head   (q_head),
    .count  (q_count),
    .empty  (q_empty),
    .full   (full_unused)
  );

  assign ROM_CS_O   = cs_reg;
  assign ROM_RD_O   = cs_reg;
  assign ROM_ADDR_O = addr_reg;
  assign OP_VALID_O = !q_empty;
  assign OP_ADDR_O  = q_head[ADDR_W+DAT_W-1:DAT_W];
  assign OP_DAT_O   = q_head[DAT_W-1:0];

`ifdef IFETCH_FLUSHCNT_EN
  logic [15:0] flush_cnt_reg;
  logic [15:0] flush_inc;

  // Bytes lost on a jump: everything queued plus the in-flight strobed byte.
  assign flush_inc = 16'(q_count) + 16'(cs_reg && (state_reg == RUN));

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      flush_cnt_reg <= '0;
    end else if (JMP_I) begin
      flush_cnt_reg <= sat_add16(flush_cnt_reg, flush_inc);
    end
  end

  assign FLUSH_CNT_O = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue with a combinational ROM model.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_cs, rom_rd;
  logic [12:0] rom_addr;
  logic [7:0]  rom_dat;
  logic        jmp = 1'b0;
  logic [12:0] jmp_addr = '0;
  logic        hold = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [7:0]  op_dat;
  logic [12:0] op_addr;
`ifdef IFETCH_FLUSHCNT_EN
  logic [15:0] flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .CLK_I     (clk),
    .RSTN_I    (rst_n),
    .ROM_CS_O  (rom_cs),
    .ROM_RD_O  (rom_rd),
    .ROM_ADDR_O(rom_addr),
    .ROM_DAT_I (rom_dat),
    .JMP_I     (jmp),
    .JMP_ADDR_I(jmp_addr),
    .HOLD_I    (hold),
    .OP_VALID_O(op_valid),
    .OP_READY_I(op_ready),
    .OP_DAT_O  (op_dat),
    .OP_ADDR_O (op_addr)
`ifdef IFETCH_FLUSHCNT_EN
    ,
    .FLUSH_CNT_O(flush_cnt)
`endif
  );

  // ROM contents: bytes 0..7 are 8'h10..8'h17; upper address bits perturb the data.
  function automatic logic [7:0] rom_byte(input logic [12:0] a);
    return a[7:0] + 8'h10 + {a[12:8], 3'b000};
  endfunction

  assign rom_dat = (rom_cs && rom_rd) ? rom_byte(rom_addr) : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0; jmp = 1'b0; jmp_addr = '0; hold = 1'b0; op_ready = ready;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    vectors++; if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL reset_cs: got %b want 0", rom_cs); end
    vectors++; if (rom_rd !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b want 0", rom_rd); end
    vectors++; if (rom_addr !== 13'h0000) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", rom_addr); end
    vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", op_valid); end
    vectors++; if (op_dat !== 8'h00) begin miscompares++; $display("FAIL reset_opdat: got %h want 00", op_dat); end
    vectors++; if (op_addr !== 13'h0000) begin miscompares++; $display("FAIL reset_opaddr: got %h want 0000", op_addr); end
`ifdef IFETCH_FLUSHCNT_EN
    vectors++; if (flush_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_flushcnt: got %h want 0000", flush_cnt); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_cold_start();
    logic [12:0] a;
    do_reset(1'b1);
    tick();
    vectors++; if (rom_cs !== 1'b1 || rom_rd !== 1'b1) begin miscompares++; $display("FAIL cold_strobe: got cs=%b rd=%b want 1/1", rom_cs, rom_rd); end
    vectors++; if (rom_addr !== 13'h0000) begin miscompares++; $display("FAIL cold_addr: got %h want 0000", rom_addr); end
    for (int k = 0; k < 7; k++) begin
      tick();
      a = 13'(k);
      vectors++;
      if (op_valid !== 1'b1 || op_dat !== rom_byte(a) || op_addr !== a) begin
        miscompares++;
        $display("FAIL cold_byte%0d: got v=%b d=%h a=%h want v=1 d=%h a=%h", k, op_valid, op_dat, op_addr, rom_byte(a), a);
      end
    end
    $display("test_cold_start done");
  endtask

  task automatic test_backpressure();
    int n_cap;
    int pops;
    int last_c;
    logic [12:0] exp_a;
    do_reset(1'b0);
    n_cap = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rom_cs) begin
        vectors++;
        if (rom_addr !== 13'(n_cap)) begin miscompares++; $display("FAIL bp_cap_addr: got %h want %h", rom_addr, 13'(n_cap)); end
        n_cap++;
      end
    end
    vectors++; if (n_cap != 4) begin miscompares++; $display("FAIL bp_captures: got %0d want 4", n_cap); end
    vectors++; if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL bp_strobe_low: got %b want 0", rom_cs); end
    vectors++; if (op_valid !== 1'b1 || op_dat !== 8'h10 || op_addr !== 13'h0000) begin
      miscompares++; $display("FAIL bp_head: got v=%b d=%h a=%h want v=1 d=10 a=0000", op_valid, op_dat, op_addr);
    end
    op_ready = 1'b1;
    pops = 0; last_c = 0; exp_a = '0;
    for (int c = 0; c < 30 && pops < 8; c++) begin
      if (op_valid) begin
        vectors++;
        if (op_addr !== exp_a || op_dat !== rom_byte(exp_a)) begin
          miscompares++; $display("FAIL bp_pop%0d: got d=%h a=%h want d=%h a=%h", pops, op_dat, op_addr, rom_byte(exp_a), exp_a);
        end
        if (pops > 0) begin
          vectors++;
          if (c - last_c > 2) begin miscompares++; $display("FAIL bp_gap: got %0d cycles want <=2", c - last_c); end
        end
        last_c = c; exp_a++; pops++;
      end
      tick();
    end
    vectors++; if (pops != 8) begin miscompares++; $display("FAIL bp_pop_count: got %0d want 8", pops); end
    $display("test_backpressure done");
  endtask

  task automatic test_jump();
    do_reset(1'b0);
    tick(); tick(); tick(); tick();
    vectors++; if (op_valid !== 1'b1 || op_addr !== 13'h0000 || rom_cs !== 1'b1 || rom_addr !== 13'h0003) begin
      miscompares++; $display("FAIL jmp_pre: got v=%b a=%h cs=%b ra=%h want v=1 a=0000 cs=1 ra=0003", op_valid, op_addr, rom_cs, rom_addr);
    end
    jmp = 1'b1; jmp_addr = 13'h0100;
    tick();
    jmp = 1'b0; jmp_addr = '0;
    vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL jmp_valid: got %b want 0", op_valid); end
    vectors++; if (rom_cs !== 1'b0 || rom_rd !== 1'b0) begin miscompares++; $display("FAIL jmp_strobe: got cs=%b rd=%b want 0/0", rom_cs, rom_rd); end
    vectors++; if (rom_addr !== 13'h0100) begin miscompares++; $display("FAIL jmp_addr: got %h want 0100", rom_addr); end
    vectors++; if (op_addr !== 13'h0000 || op_dat !== 8'h10) begin
      miscompares++; $display("FAIL jmp_head_hold: got d=%h a=%h want d=10 a=0000", op_dat, op_addr);
    end
`ifdef IFETCH_FLUSHCNT_EN
    vectors++; if (flush_cnt !== 16'd4) begin miscompares++; $display("FAIL jmp_flushcnt: got %0d want 4", flush_cnt); end
`endif
    tick();
    vectors++; if (rom_cs !== 1'b1 || rom_addr !== 13'h0100) begin
      miscompares++; $display("FAIL jmp_refetch: got cs=%b a=%h want cs=1 a=0100", rom_cs, rom_addr);
    end
    op_ready = 1'b1;
    tick();
    vectors++; if (op_valid !== 1'b1 || op_addr !== 13'h0100 || op_dat !== rom_byte(13'h0100)) begin
      miscompares++; $display("FAIL jmp_first: got v=%b d=%h a=%h want v=1 d=%h a=0100", op_valid, op_dat, op_addr, rom_byte(13'h0100));
    end
    $display("test_jump done");
  endtask

  task automatic test_wrap();
    logic [12:0] exp_list [4];
    int pops;
    exp_list = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    do_reset(1'b1);
    tick(); tick(); tick();
    jmp = 1'b1; jmp_addr = 13'h1FFE;
    tick();
    jmp = 1'b0; jmp_addr = '0;
    pops = 0;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      if (op_valid) begin
        vectors++;
        if (op_addr !== exp_list[pops] || op_dat !== rom_byte(exp_list[pops])) begin
          miscompares++; $display("FAIL wrap_pop%0d: got d=%h a=%h want d=%h a=%h", pops, op_dat, op_addr, rom_byte(exp_list[pops]), exp_list[pops]);
        end
        pops++;
      end
      tick();
    end
    vectors++; if (pops != 4) begin miscompares++; $display("FAIL wrap_count: got %0d want 4", pops); end
    $display("test_wrap done");
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    tick(); tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (rom_cs !== 1'b0 || rom_rd !== 1'b0) begin miscompares++; $display("FAIL areset_strobe: got cs=%b rd=%b want 0/0", rom_cs, rom_rd); end
    vectors++; if (rom_addr !== 13'h0000) begin miscompares++; $display("FAIL areset_addr: got %h want 0000", rom_addr); end
    vectors++; if (op_valid !== 1'b0 || op_dat !== 8'h00 || op_addr !== 13'h0000) begin
      miscompares++; $display("FAIL areset_op: got v=%b d=%h a=%h want 0/00/0000", op_valid, op_dat, op_addr);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (rom_cs !== 1'b1 || rom_addr !== 13'h0000) begin
      miscompares++; $display("FAIL areset_restart: got cs=%b a=%h want cs=1 a=0000", rom_cs, rom_addr);
    end
    tick();
    vectors++; if (op_valid !== 1'b1 || op_addr !== 13'h0000 || op_dat !== 8'h10) begin
      miscompares++; $display("FAIL areset_first: got v=%b d=%h a=%h want v=1 d=10 a=0000", op_valid, op_dat, op_addr);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_hold();
    logic [12:0] exp_a;
    int pops;
    do_reset(1'b1);
    exp_a = '0; pops = 0;
    for (int c = 0; c < 40 && pops < 16; c++) begin
      hold = (c >= 4 && c < 9);
      if (op_valid) begin
        vectors++;
        if (op_addr !== exp_a || op_dat !== rom_byte(exp_a)) begin
          miscompares++; $display("FAIL hold_pop%0d: got d=%h a=%h want d=%h a=%h", pops, op_dat, op_addr, rom_byte(exp_a), exp_a);
        end
        exp_a++; pops++;
      end
      tick();
      if (c >= 4 && c < 9) begin
        vectors++;
        if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL hold_strobe_c%0d: got %b want 0", c, rom_cs); end
      end
      if (c == 8) begin
        vectors++;
        if (op_valid !== 1'b0) begin miscompares++; $display("FAIL hold_drained: got %b want 0", op_valid); end
      end
    end
    hold = 1'b0;
    vectors++; if (pops != 16) begin miscompares++; $display("FAIL hold_pop_count: got %0d want 16", pops); end
    $display("test_hold done");
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_backpressure();
    test_jump();
    test_wrap();
    test_async_reset();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
